// File: rtl/ring_osc_counter_if.sv
// ring_osc_counter_if
//   Groups the measurement control, the ring oscillator link and the result
//   signals of ring_osc_counter into one bundle.
//   master : logic analyser / environment side. It drives start, abort,
//            window_len and the ring oscillator output ring_in.
//   slave  : the measurement block. It drives ring_en, busy, done, overflow
//            and count.
// Signals
//   start       level; a rising edge starts a measurement
//   abort       synchronous abort back to idle
//   window_len  count window in clock cycles, latched at start
//   ring_in     ring oscillator output, asynchronous to the clock
//   ring_en     enable to the ring oscillator
//   busy        settling or counting
//   done        measurement finished, count valid
//   overflow    edge counter saturated during this measurement
//   count       rising edges seen during the count window
interface ring_osc_counter_if #(
    parameter int COUNT_W  = 32,
    parameter int WINDOW_W = 32
);
    logic                start;
    logic                abort;
    logic [WINDOW_W-1:0] window_len;
    logic                ring_in;
    logic                ring_en;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [COUNT_W-1:0]  count;

    modport master (
        output start, abort, window_len, ring_in,
        input  ring_en, busy, done, overflow, count
    );

    modport slave (
        input  start, abort, window_len, ring_in,
        output ring_en, busy, done, overflow, count
    );
endinterface

// File: rtl/ring_osc_counter.sv
// ring_osc_counter
//   Measurement stage for the instrumented adder ring oscillator. A rising
//   edge on start enables the ring, lets it run for SETTLE cycles (which also
//   flushes stale values out of the synchroniser), then counts rising edges of
//   the synchronised ring output for window_len clock cycles. count, done and
//   overflow are held until the next start edge or an abort.
// Ports
//   wb_clk_i  in   system clock
//   reset_n   in   asynchronous active-low reset
//   bus       slave modport of ring_osc_counter_if (control, ring link, results)
// Parameters
//   COUNT_W      edge counter width
//   WINDOW_W     window length width
//   SYNC_STAGES  flops in the ring_in synchroniser (>= 2)
//   SETTLE       ring run-in cycles before counting (>= SYNC_STAGES + 1)
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ring off, outputs cleared, waiting for a start edge
// S_SETTLE | ring running, synchroniser flushing, edges ignored
// S_COUNT  | ring running, synchronised rising edges counted
// S_DONE   | ring off, count/overflow valid and held
module ring_osc_counter #(
    parameter int COUNT_W     = 32,
    parameter int WINDOW_W    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 4
) (
    input  logic              wb_clk_i,
    input  logic              reset_n,
    ring_osc_counter_if.slave bus
);

    localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);
    localparam logic [COUNT_W-1:0]  COUNT_MAX   = '1;
    localparam logic [WINDOW_W-1:0] WIN_LAST    = WINDOW_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COUNT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   r_start_q;

    logic [WINDOW_W-1:0]    r_win;
    logic [WINDOW_W-1:0]    w_win_nxt;
    logic [SETTLE_W-1:0]    r_settle_ctr;
    logic [SETTLE_W-1:0]    w_settle_ctr_nxt;
    logic [COUNT_W-1:0]     r_count;
    logic [COUNT_W-1:0]     w_count_nxt;

    logic                   r_ring_en;
    logic                   w_ring_en_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   r_overflow;
    logic                   w_overflow_nxt;

    logic                   w_trigger;
    logic                   w_edge;

    // ring_in is asynchronous; only the last synchroniser stage is ever looked at.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_start_q   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.ring_in};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
            r_start_q   <= bus.start;
        end
    end

    assign w_trigger = bus.start & ~r_start_q;
    assign w_edge    = r_sync[SYNC_STAGES-1] & ~r_sync_prev;

    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_win        <= '0;
            r_settle_ctr <= '0;
            r_count      <= '0;
            r_ring_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_win        <= w_win_nxt;
            r_settle_ctr <= w_settle_ctr_nxt;
            r_count      <= w_count_nxt;
            r_ring_en    <= w_ring_en_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_overflow   <= w_overflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_win_nxt        = r_win;
        w_settle_ctr_nxt = r_settle_ctr;
        w_count_nxt      = r_count;
        w_ring_en_nxt    = r_ring_en;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;
        w_overflow_nxt   = r_overflow;

        if (bus.abort) begin
            // abort wins over a coincident start edge
            w_state_nxt    = S_IDLE;
            w_count_nxt    = '0;
            w_ring_en_nxt  = 1'b0;
            w_busy_nxt     = 1'b0;
            w_done_nxt     = 1'b0;
            w_overflow_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_trigger) begin
                        w_count_nxt    = '0;
                        w_overflow_nxt = 1'b0;
                        if (bus.window_len != '0) begin
                            w_state_nxt      = S_SETTLE;
                            w_win_nxt        = bus.window_len;
                            w_settle_ctr_nxt = SETTLE_LOAD;
                            w_ring_en_nxt    = 1'b1;
                            w_busy_nxt       = 1'b1;
                            w_done_nxt       = 1'b0;
                        end else begin
                            // empty window: finish at once, ring never enabled
                            w_state_nxt   = S_DONE;
                            w_ring_en_nxt = 1'b0;
                            w_busy_nxt    = 1'b0;
                            w_done_nxt    = 1'b1;
                        end
                    end
                end

                S_SETTLE: begin
                    if (r_settle_ctr == '0) begin
                        w_state_nxt = S_COUNT;
                    end else begin
                        w_settle_ctr_nxt = r_settle_ctr - SETTLE_W'(1);
                    end
                end

                S_COUNT: begin
                    if (w_edge) begin
                        // saturate; an edge arriving at full scale is a lost edge
                        if (r_count == COUNT_MAX) begin
                            w_overflow_nxt = 1'b1;
                        end else begin
                            w_count_nxt = r_count + COUNT_W'(1);
                        end
                    end
                    // r_win runs window_len..1, one value per COUNT cycle
                    if (r_win == WIN_LAST) begin
                        w_state_nxt   = S_DONE;
                        w_ring_en_nxt = 1'b0;
                        w_busy_nxt    = 1'b0;
                        w_done_nxt    = 1'b1;
                    end else begin
                        w_win_nxt = r_win - WIN_LAST;
                    end
                end

                default: begin
                    w_state_nxt   = S_IDLE;
                    w_ring_en_nxt = 1'b0;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b0;
                end
            endcase
        end
    end

    assign bus.ring_en  = r_ring_en;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.overflow = r_overflow;
    assign bus.count    = r_count;

endmodule

// File: tb/tb_ring_osc_counter.sv
module tb_ring_osc_counter;

    localparam int S    = 4;
    localparam int SYNC = 2;
    localparam int MAX4 = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    int   e0     = 0;

    ring_osc_counter_if #(.COUNT_W(32), .WINDOW_W(32)) bus32 ();
    ring_osc_counter_if #(.COUNT_W(4),  .WINDOW_W(32)) bus4  ();

    ring_osc_counter #(.COUNT_W(32), .WINDOW_W(32), .SYNC_STAGES(SYNC), .SETTLE(S)) dut (
        .wb_clk_i (clk),
        .reset_n  (rst_n),
        .bus      (bus32)
    );

    ring_osc_counter #(.COUNT_W(4), .WINDOW_W(32), .SYNC_STAGES(SYNC), .SETTLE(S)) dut4 (
        .wb_clk_i (clk),
        .reset_n  (rst_n),
        .bus      (bus4)
    );

    assign bus4.start      = bus32.start;
    assign bus4.abort      = bus32.abort;
    assign bus4.window_len = bus32.window_len;
    assign bus4.ring_in    = bus32.ring_in;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ring oscillator model: runs only while enabled, output low when stopped.
    // Each rise is logged with the index of the clock edge that first samples it.
    int ring_period = 8;
    int ring_high   = 4;
    int ring_ph0    = 0;
    int ring_ph     = 0;
    int rise_q[$];

    initial begin
        bus32.ring_in = 1'b0;
        forever begin
            @(negedge clk);
            if (bus32.ring_en === 1'b1) begin
                if (ring_ph < ring_high && bus32.ring_in == 1'b0) rise_q.push_back(cyc + 1);
                bus32.ring_in = (ring_ph < ring_high);
                ring_ph = (ring_ph + 1) % ring_period;
            end else begin
                bus32.ring_in = 1'b0;
                ring_ph = ring_ph0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a rise sampled at edge k reaches the edge detector SYNC edges
    // later and is counted iff that edge is one of the window_len COUNT edges,
    // which follow the trigger edge e0 and SETTLE settle edges.
    function automatic int model_edges(input int w);
        int n = 0;
        foreach (rise_q[i]) begin
            if (rise_q[i] + SYNC >= e0 + S + 1 && rise_q[i] + SYNC <= e0 + S + w) n++;
        end
        return n;
    endfunction

    task automatic launch(input int w, input int p, input int h, input int ph);
        bus32.start = 1'b0;
        ring_period = p;
        ring_high   = h;
        ring_ph0    = ph;
        tick();
        bus32.window_len = w;
        bus32.start      = 1'b1;
        rise_q.delete();
        e0 = cyc + 1;
    endtask

    task automatic wait_done(output int lat, output int en_cyc, output bit tmo);
        en_cyc = 0;
        lat    = -1;
        tmo    = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (bus32.done === 1'b1) begin
                lat = cyc - e0 + 1;
                tmo = 1'b0;
                break;
            end
            if (bus32.ring_en === 1'b1) en_cyc++;
        end
    endtask

    task automatic check_result(input string tag, input int w, input int lat, input int en_cyc,
                                input bit tmo, input int n);
        int n4 = (n > MAX4) ? MAX4 : n;
        chk({tag, ".timeout"}, tmo, 0);
        chk({tag, ".latency"}, lat, (w == 0) ? 1 : 1 + S + w);
        chk({tag, ".ring_en_cycles"}, en_cyc, (w == 0) ? 0 : S + w);
        chk({tag, ".done4"}, bus4.done, 1);
        chk({tag, ".busy"}, bus32.busy, 0);
        chk({tag, ".ring_en_off"}, bus32.ring_en, 0);
        chk({tag, ".count"}, bus32.count, n);
        chk({tag, ".overflow"}, bus32.overflow, 0);
        chk({tag, ".count4"}, bus4.count, n4);
        chk({tag, ".overflow4"}, bus4.overflow, (n > MAX4));
    endtask

    typedef struct {
        int win;
        int per;
        int hi;
        int exp_n;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat, en_cyc, n, w, p, h;
        bit tmo;

        vecs[0] = '{80,  8,  4, 10};
        vecs[1] = '{0,   8,  4, 0};
        vecs[2] = '{100, 4,  2, 25};
        vecs[3] = '{48,  6,  3, 8};
        vecs[4] = '{60,  3,  1, 20};
        vecs[5] = '{16,  16, 8, 1};
        vecs[6] = '{36,  12, 5, 3};

        bus32.start      = 1'b0;
        bus32.abort      = 1'b0;
        bus32.window_len = '0;

        // reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst.ring_en", bus32.ring_en, 0);
        chk("rst.busy", bus32.busy, 0);
        chk("rst.done", bus32.done, 0);
        chk("rst.overflow", bus32.overflow, 0);
        chk("rst.count", bus32.count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst.busy", bus32.busy, 0);
        chk("post_rst.done", bus32.done, 0);

        // table-driven measurements; counts are phase-independent (window is a multiple of the period)
        foreach (vecs[i]) begin
            launch(vecs[i].win, vecs[i].per, vecs[i].hi, $urandom_range(0, vecs[i].per - 1));
            wait_done(lat, en_cyc, tmo);
            check_result($sformatf("vec%0d", i), vecs[i].win, lat, en_cyc, tmo, vecs[i].exp_n);
            tick();
            tick();
            chk($sformatf("vec%0d.hold_done", i), bus32.done, 1);
            chk($sformatf("vec%0d.hold_count", i), bus32.count, vecs[i].exp_n);
        end

        // randomized measurements against the edge-window model
        for (int i = 0; i < 12; i++) begin
            p = $urandom_range(3, 12);
            h = $urandom_range(1, p - 1);
            w = $urandom_range(0, 70);
            launch(w, p, h, $urandom_range(0, p - 1));
            wait_done(lat, en_cyc, tmo);
            n = model_edges(w);
            check_result($sformatf("rnd%0d", i), w, lat, en_cyc, tmo, n);
        end

        // start held high through DONE, then low for one clock and high again
        launch(100, 4, 2, 1);
        wait_done(lat, en_cyc, tmo);
        check_result("hold", 100, lat, en_cyc, tmo, 25);
        for (int i = 0; i < 5; i++) tick();
        chk("hold.no_retrigger_busy", bus32.busy, 0);
        chk("hold.done_kept", bus32.done, 1);
        chk("hold.count_kept", bus32.count, 25);
        launch(20, 4, 2, 0);
        tick();
        chk("retrig.done_cleared", bus32.done, 0);
        chk("retrig.busy", bus32.busy, 1);
        chk("retrig.count_cleared", bus32.count, 0);
        chk("retrig.overflow4_cleared", bus4.overflow, 0);
        wait_done(lat, en_cyc, tmo);
        chk("retrig.timeout", tmo, 0);
        chk("retrig.latency", lat, 1 + S + 20);
        chk("retrig.count", bus32.count, 5);

        // start edge while busy is ignored and a new window_len has no effect
        launch(40, 8, 4, 3);
        tick();
        tick();
        bus32.start = 1'b0;
        tick();
        bus32.window_len = 7;
        bus32.start = 1'b1;
        tick();
        chk("busy_retrig.busy", bus32.busy, 1);
        wait_done(lat, en_cyc, tmo);
        chk("busy_retrig.timeout", tmo, 0);
        chk("busy_retrig.latency", lat, 1 + S + 40);
        chk("busy_retrig.count", bus32.count, 5);

        // abort at COUNT cycle 20 coinciding with a new start edge
        launch(50, 4, 2, 0);
        while (cyc < e0 + S + 18) tick();
        bus32.start = 1'b0;
        chk("abort.busy_before", bus32.busy, 1);
        tick();
        bus32.start = 1'b1;
        bus32.abort = 1'b1;
        tick();
        chk("abort.busy", bus32.busy, 0);
        chk("abort.ring_en", bus32.ring_en, 0);
        chk("abort.done", bus32.done, 0);
        chk("abort.count", bus32.count, 0);
        chk("abort.count4", bus4.count, 0);
        chk("abort.overflow", bus32.overflow, 0);
        bus32.abort = 1'b0;
        tick();
        tick();
        chk("abort.idle_busy", bus32.busy, 0);
        chk("abort.idle_done", bus32.done, 0);

        // reset mid-COUNT: outputs clear immediately
        launch(50, 4, 2, 0);
        while (cyc < e0 + S + 10) tick();
        chk("rst_mid.busy_before", bus32.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.ring_en", bus32.ring_en, 0);
        chk("rst_mid.busy", bus32.busy, 0);
        chk("rst_mid.done", bus32.done, 0);
        chk("rst_mid.count", bus32.count, 0);
        chk("rst_mid.count4", bus4.count, 0);
        chk("rst_mid.overflow", bus32.overflow, 0);
        tick();
        bus32.start = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst_mid.idle_busy", bus32.busy, 0);
        chk("rst_mid.idle_done", bus32.done, 0);
        chk("rst_mid.idle_ring_en", bus32.ring_en, 0);
        launch(8, 4, 2, 2);
        wait_done(lat, en_cyc, tmo);
        check_result("rst_recover", 8, lat, en_cyc, tmo, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
